eeprom_28c_page_emu: RTL and testbench

Parametrised emulation of a 28C-series parallel EEPROM with page-mode writes, byte-load window, data polling and toggle-bit status, plus a MiSTer ioctl port for NVRAM load/save. It replaces single-byte EEPROM models in the board top level wherever game code writes bursts of bytes and polls for completion.

---
 rtl/eeprom_28c_page_emu.sv | 227 ++++++++++++++++++++++
 tb/tb_eeprom_28c_page_emu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/eeprom_28c_page_emu.sv
// eeprom_28c_page_emu
// Emulates a 28C-series parallel EEPROM with page-mode writes. A write from
// IDLE opens a byte-load window. Further writes to the same page fill a page
// buffer. Once the window expires, the buffered bytes are committed one
// offset per tick and then an internal programming delay runs. While busy,
// reads return data-polling / toggle-bit status. A MiSTer ioctl port loads
// and saves the array as NVRAM.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   ce                   clock enable for all EEPROM-side state and timers
//   wr, rd, addr, data   EEPROM bus (strobes sampled when ce is high)
//   q                    registered read data / status
//   ready                high only while idle
//   modified             set by an accepted write, cleared by an upload edge
//   ioctl_download/wr/addr/dout   host load port (writes the array)
//   ioctl_upload                  host save request (edge clears modified)
//   ioctl_din                     host read data, one clk latency
//   ioctl_rd                      host read strobe (unused by the model)
module eeprom_28c_page_emu #(
    parameter int ADDR_W       = 13,
    parameter int PAGE_W       = 6,
    parameter int LOAD_WINDOW  = 150,
    parameter int WRITE_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data,
    output logic [7:0]        q,
    output logic              ready,
    output logic              modified,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_upload,
    output logic [7:0]        ioctl_din,
    input  logic              ioctl_rd
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int PAGE_SZ = 1 << PAGE_W;
    localparam int PG_W    = ADDR_W - PAGE_W;
    localparam int LT_W    = $clog2(LOAD_WINDOW + 1);
    localparam int PT_W    = $clog2(WRITE_CYCLES + 1);

    localparam logic [LT_W-1:0] LOAD_LAST = LT_W'(LOAD_WINDOW);
    localparam logic [PT_W-1:0] PROG_INIT = PT_W'(WRITE_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_PROG   = 2'd3;

    logic [7:0] mem      [DEPTH];
    logic [7:0] page_buf [PAGE_SZ];

    logic [1:0]         state_q, state_d;
    logic [PG_W-1:0]    page_q, page_d;
    logic [PAGE_SZ-1:0] valid_q, valid_d;
    logic [7:0]         last_byte_q, last_byte_d;
    logic [LT_W-1:0]    load_timer_q, load_timer_d;
    logic [PAGE_W-1:0]  offset_q, offset_d;
    logic [PT_W-1:0]    prog_timer_q, prog_timer_d;
    logic               toggle_q, toggle_d;
    logic [7:0]         q_q, q_d;
    logic               modified_q, modified_d;
    logic               upload_prev_q, upload_prev_d;
    logic [7:0]         ioctl_din_q, ioctl_din_d;

    logic               buf_we;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [7:0]         mem_wdata;
    logic               wr_accept;
    logic               unused_ioctl_rd;

    assign unused_ioctl_rd = ioctl_rd;
    assign q         = q_q;
    assign ready     = (state_q == S_IDLE);
    assign modified  = modified_q;
    assign ioctl_din = ioctl_din_q;

    always_comb begin
        state_d       = state_q;
        page_d        = page_q;
        valid_d       = valid_q;
        last_byte_d   = last_byte_q;
        load_timer_d  = load_timer_q;
        offset_d      = offset_q;
        prog_timer_d  = prog_timer_q;
        toggle_d      = toggle_q;
        q_d           = q_q;
        modified_d    = modified_q;
        upload_prev_d = ioctl_upload;
        ioctl_din_d   = mem[ioctl_addr];
        buf_we        = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = ioctl_addr;
        mem_wdata     = ioctl_dout;
        wr_accept     = 1'b0;

        // Reads see the state as it was before this tick.
        if (ce && rd) begin
            if (state_q == S_IDLE) begin
                q_d = mem[addr];
            end else begin
                q_d      = {~last_byte_q[7], toggle_q, last_byte_q[5:0]};
                toggle_d = ~toggle_q;
            end
        end

        if (ioctl_download) begin
            // Host load owns the array; any in-flight page write is dropped.
            state_d      = S_IDLE;
            valid_d      = '0;
            load_timer_d = '0;
            prog_timer_d = '0;
            mem_we       = ioctl_wr;
        end else if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (wr) begin
                        page_d                    = addr[ADDR_W-1:PAGE_W];
                        buf_we                    = 1'b1;
                        valid_d[addr[PAGE_W-1:0]] = 1'b1;
                        last_byte_d               = data;
                        load_timer_d              = '0;
                        wr_accept                 = 1'b1;
                        state_d                   = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (wr && (addr[ADDR_W-1:PAGE_W] == page_q)) begin
                        buf_we                    = 1'b1;
                        valid_d[addr[PAGE_W-1:0]] = 1'b1;
                        last_byte_d               = data;
                        load_timer_d              = '0;
                        wr_accept                 = 1'b1;
                    end else begin
                        // A write to another page does not extend the window.
                        load_timer_d = load_timer_q + LT_W'(1);
                        if (load_timer_d == LOAD_LAST) begin
                            offset_d = '0;
                            state_d  = S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    // Reset stops the commit between bytes, never inside one.
                    mem_we    = valid_q[offset_q] && !reset;
                    mem_waddr = {page_q, offset_q};
                    mem_wdata = page_buf[offset_q];
                    if (offset_q == '1) begin
                        valid_d      = '0;
                        prog_timer_d = PROG_INIT;
                        state_d      = S_PROG;
                    end else begin
                        offset_d = offset_q + PAGE_W'(1);
                    end
                end
                default: begin
                    if (prog_timer_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        prog_timer_d = prog_timer_q - PT_W'(1);
                    end
                end
            endcase
        end

        if (state_d == S_IDLE) begin
            toggle_d = 1'b0;
        end

        // An accepted write in the same cycle as the upload edge wins.
        if (ioctl_upload && !upload_prev_q) begin
            modified_d = 1'b0;
        end
        if (wr_accept) begin
            modified_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            page_q        <= '0;
            valid_q       <= '0;
            last_byte_q   <= '0;
            load_timer_q  <= '0;
            offset_q      <= '0;
            prog_timer_q  <= '0;
            toggle_q      <= 1'b0;
            q_q           <= '0;
            modified_q    <= 1'b0;
            upload_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            page_q        <= page_d;
            valid_q       <= valid_d;
            last_byte_q   <= last_byte_d;
            load_timer_q  <= load_timer_d;
            offset_q      <= offset_d;
            prog_timer_q  <= prog_timer_d;
            toggle_q      <= toggle_d;
            q_q           <= q_d;
            modified_q    <= modified_d;
            upload_prev_q <= upload_prev_d;
        end
    end

    // Array storage is not reset: contents survive reset.
    always_ff @(posedge clk) begin
        ioctl_din_q <= ioctl_din_d;
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (buf_we) begin
            page_buf[addr[PAGE_W-1:0]] <= data;
        end
    end

endmodule

// File: tb/tb_eeprom_28c_page_emu.sv
module tb_eeprom_28c_page_emu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [12:0] addr = '0;
    logic [7:0]  data = '0;
    logic [7:0]  q;
    logic        ready;
    logic        modified;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [12:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_din;
    logic        ioctl_rd = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc;
    logic [6:0] toggles;

    eeprom_28c_page_emu #(
        .ADDR_W(13), .PAGE_W(6), .LOAD_WINDOW(150), .WRITE_CYCLES(1000)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .wr(wr), .rd(rd), .addr(addr),
        .data(data), .q(q), .ready(ready), .modified(modified),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_upload(ioctl_upload), .ioctl_din(ioctl_din),
        .ioctl_rd(ioctl_rd)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [12:0] a, input logic [7:0] d);
        addr = a; data = d; wr = 1'b1;
        step(1);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [12:0] a);
        addr = a; rd = 1'b1;
        step(1);
        rd = 1'b0;
    endtask

    task automatic host_write(input logic [12:0] a, input logic [7:0] d);
        ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        step(1);
        ioctl_wr = 1'b0;
    endtask

    task automatic upload_edge();
        ioctl_upload = 1'b1;
        step(1);
        ioctl_upload = 1'b0;
        step(1);
    endtask

    task automatic wait_ready(input int budget, output int cycles);
        cycles = 0;
        while (!ready && cycles < budget) begin
            step(1);
            cycles++;
        end
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        chk("reset_q", q, 8'h00);
        chk("reset_ready", ready, 1'b1);
        chk("reset_modified", modified, 1'b0);

        // Preload known contents through the host port.
        ioctl_download = 1'b1;
        host_write(13'h1FFF, 8'hA5);
        host_write(13'h0240, 8'h77);
        host_write(13'h0010, 8'h99);
        for (int i = 0; i < 8; i++) host_write(13'h0300 + 13'(i), 8'hEE);
        ioctl_download = 1'b0;
        step(1);
        chk("dl_modified", modified, 1'b0);
        bus_read(13'h1FFF);
        chk("dl_read_q", q, 8'hA5);
        ioctl_addr = 13'h1FFF;
        step(1);
        chk("dl_ioctl_din", ioctl_din, 8'hA5);

        // Single byte write and busy duration.
        bus_write(13'h0100, 8'h5A);
        chk("wr1_ready_low", ready, 1'b0);
        chk("wr1_modified", modified, 1'b1);
        wait_ready(3000, cyc);
        chk("wr1_busy_ticks", cyc, 1214);
        bus_read(13'h0100);
        chk("wr1_read", q, 8'h5A);

        // Multi-byte page load, other-page write ignored.
        bus_write(13'h0200, 8'h11); step(9);
        bus_write(13'h0201, 8'h22); step(9);
        bus_write(13'h0202, 8'h33); step(9);
        bus_write(13'h0240, 8'h44);
        wait_ready(3000, cyc);
        chk("page_ready", ready, 1'b1);
        bus_read(13'h0200); chk("page_0200", q, 8'h11);
        bus_read(13'h0201); chk("page_0201", q, 8'h22);
        bus_read(13'h0202); chk("page_0202", q, 8'h33);
        bus_read(13'h0240); chk("page_0240", q, 8'h77);

        // Data polling and toggle bit.
        bus_write(13'h0080, 8'h80);
        bus_read(13'h0080);
        chk("poll_q7", q[7], 1'b0);
        toggles[0] = q[6];
        bus_read(13'h0080);
        toggles[1] = q[6];
        bus_read(13'h0080);
        toggles[2] = q[6];
        chk("poll_toggle", {29'd0, toggles[2:0]}, 32'b010);
        chk("poll_status", q, 8'h00);
        wait_ready(3000, cyc);
        chk("poll_ready", ready, 1'b1);
        bus_read(13'h0080);
        chk("poll_final", q, 8'h80);
        upload_edge();
        chk("upload_clear1", modified, 1'b0);

        // Write during PROG is ignored.
        bus_write(13'h0500, 8'h3C);
        step(220);
        chk("prog_busy", ready, 1'b0);
        upload_edge();
        chk("prog_upload_clear", modified, 1'b0);
        bus_write(13'h0010, 8'h12);
        chk("prog_wr_modified", modified, 1'b0);
        wait_ready(3000, cyc);
        chk("prog_ready", ready, 1'b1);
        bus_read(13'h0010); chk("prog_0010", q, 8'h99);
        bus_read(13'h0500); chk("prog_0500", q, 8'h3C);

        // Reset while committing offset 3 of a page load.
        for (int i = 0; i < 8; i++) bus_write(13'h0300 + 13'(i), 8'hC0 + 8'(i));
        step(153);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst_commit_ready", ready, 1'b1);
        chk("rst_commit_modified", modified, 1'b0);
        chk("rst_commit_q", q, 8'h00);
        bus_read(13'h0300); chk("rst_0300", q, 8'hC0);
        bus_read(13'h0301); chk("rst_0301", q, 8'hC1);
        bus_read(13'h0302); chk("rst_0302", q, 8'hC2);
        bus_read(13'h0303); chk("rst_0303", q, 8'hEE);
        bus_read(13'h0307); chk("rst_0307", q, 8'hEE);
        ioctl_addr = 13'h0302;
        step(1);
        chk("rst_ioctl_din", ioctl_din, 8'hC2);

        // ce low freezes q and blocks writes.
        bus_read(13'h0100);
        chk("ce_pre", q, 8'h5A);
        ce = 1'b0;
        addr = 13'h1FFF; rd = 1'b1; wr = 1'b1; data = 8'h01;
        step(2);
        rd = 1'b0; wr = 1'b0;
        chk("ce_hold_q", q, 8'h5A);
        chk("ce_hold_ready", ready, 1'b1);
        ce = 1'b1;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
